// File: rtl/uart_imem_loader.sv
// ---------------------------------------------------------------------------
// uart_imem_loader
//
// Boot-time program loader. Parses a framed byte stream from the UART
// receive path and writes the payload into instruction memory over
// Wishbone. The rv32i core is held in reset until the whole image is written.
//
// Frame: SYNC_BYTE, count[7:0], count[15:8], then count little-endian
// 32-bit words. Word i is written to BASE_ADDR + 4*i.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   i_rx_valid/i_rx_data one-cycle strobe carrying a received byte
//   o_wb_*              Wishbone master write port (single writes)
//   i_wb_ack            Wishbone slave acknowledge
//   o_core_rst_n        core reset, released once the image is loaded
//   o_busy              frame in progress
//   o_done              image loaded (sticky until reset)
//   o_error             bad length or receive overrun (sticky until reset)
// ---------------------------------------------------------------------------
module uart_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  output logic        o_core_rst_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic        hold_valid;
  logic [7:0]  hold_data;

  // Length as it will be once the high byte currently on i_rx_data lands.
  logic [15:0] len_full;
  logic        len_bad;
  // In DATA a byte parked during the previous WRITE takes precedence over
  // the live strobe; a live byte arriving alongside it is re-parked.
  logic        data_have;
  logic [7:0]  data_byte;
  logic [31:0] next_adr;
  logic        last_word;

  assign len_full  = {i_rx_data, count[7:0]};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
  assign data_have = hold_valid | i_rx_valid;
  assign data_byte = hold_valid ? hold_data : i_rx_data;
  assign next_adr  = BASE_ADDR + {14'd0, word_idx, 2'b00};
  assign last_word = (word_idx + 16'd1) == count;

  always_ff @(posedge clk) begin
    // NOTE: every register, including the byte hold buffer and the partial
    // word, is cleared so a reset mid-frame leaves nothing of the old image.
    if (!reset_n) begin
      state        <= S_IDLE;
      count        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_adr     <= '0;
      o_wb_dat     <= '0;
      o_wb_sel     <= '0;
      o_core_rst_n <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the register values from before this edge.
      case (state)
        S_IDLE: begin
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            state  <= S_LEN_LO;
            o_busy <= 1'b1;
          end
        end

        S_LEN_LO: begin
          if (i_rx_valid) begin
            count[7:0] <= i_rx_data;
            state      <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (i_rx_valid) begin
            count[15:8] <= i_rx_data;
            word_idx    <= '0;
            byte_idx    <= '0;
            if (len_bad) begin
              state   <= S_ERROR;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          hold_valid <= hold_valid & i_rx_valid;
          hold_data  <= i_rx_data;
          if (data_have) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= data_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              o_wb_cyc <= 1'b1;
              o_wb_stb <= 1'b1;
              o_wb_we  <= 1'b1;
              o_wb_sel <= 4'hF;
              o_wb_adr <= next_adr;
              o_wb_dat <= {data_byte, word_buf[23:0]};
            end
          end
        end

        S_WRITE: begin
          if (i_rx_valid && hold_valid) begin
            // Second byte while one is already parked: overrun.
            state    <= S_ERROR;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= 4'h0;
            o_busy   <= 1'b0;
            o_error  <= 1'b1;
          end else begin
            if (i_rx_valid) begin
              hold_valid <= 1'b1;
              hold_data  <= i_rx_data;
            end
            if (i_wb_ack) begin
              o_wb_cyc <= 1'b0;
              o_wb_stb <= 1'b0;
              o_wb_we  <= 1'b0;
              o_wb_sel <= 4'h0;
              word_idx <= word_idx + 16'd1;
              byte_idx <= '0;
              if (last_word) begin
                state        <= S_DONE;
                o_busy       <= 1'b0;
                o_done       <= 1'b1;
                o_core_rst_n <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DONE, S_ERROR: begin
          // Terminal until reset; received bytes are ignored.
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
